// File: rtl/serial_tx_arbiter_if.sv
// Byte-producer and serial-port signals of the two-requester serial transmit arbiter.
// slave is the arbiter's view; master is the view of whatever drives the requesters and port.
interface serial_tx_arbiter_if;
    logic [7:0] req0_data;
    logic       req0_wren;
    logic       req0_full;
    logic [7:0] req1_data;
    logic       req1_wren;
    logic       req1_full;
    logic       serial_ready_in;
    logic [7:0] serial_out;
    logic       serial_wren_out;
    logic       busy;
    logic [7:0] drop_count;

    // Push: a byte is taken on every edge with reqN_wren=1 and reqN_full=0, otherwise dropped.
    // Output: serial_wren_out=1 marks a byte the port must accept; it is only issued after an
    // edge where serial_ready_in=1 was sampled.
    modport slave (
        input  req0_data, req0_wren, req1_data, req1_wren, serial_ready_in,
        output req0_full, req1_full, serial_out, serial_wren_out, busy, drop_count
    );
    modport master (
        output req0_data, req0_wren, req1_data, req1_wren, serial_ready_in,
        input  req0_full, req1_full, serial_out, serial_wren_out, busy, drop_count
    );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Two per-requester byte FIFOs drained round-robin onto a single registered serial port.
// Saturating drop counter records bytes pushed into a full FIFO.
module serial_tx_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    serial_tx_arbiter_if.slave   bus
);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    mem_q [2][DEPTH];
    logic [AW-1:0] rd_q [2];
    logic [AW-1:0] rd_d [2];
    logic [AW-1:0] wr_q [2];
    logic [AW-1:0] wr_d [2];
    logic [AW:0]   cnt_q [2];
    logic [AW:0]   cnt_d [2];
    logic          last_grant_q, last_grant_d;
    logic [7:0]    serial_out_q, serial_out_d;
    logic          serial_wren_q, serial_wren_d;
    logic [7:0]    drop_count_q, drop_count_d;

    logic [7:0]    wr_data [2];
    logic          wren [2];
    logic          full [2];
    logic          nonempty [2];
    logic          push [2];
    logic          pop [2];
    logic          grant_valid;
    logic          grant_sel;
    logic [1:0]    drop_n;
    logic [8:0]    drop_sum;

    always_comb begin
        wr_data[0] = bus.req0_data;
        wr_data[1] = bus.req1_data;
        wren[0]    = bus.req0_wren;
        wren[1]    = bus.req1_wren;
        for (int i = 0; i < 2; i++) begin
            full[i]     = (cnt_q[i] == FULL_CNT);
            nonempty[i] = (cnt_q[i] != '0);
            // Fullness comes from the registered count, so a same-edge pop never frees a slot.
            push[i]     = wren[i] && !full[i];
        end

        grant_valid = bus.serial_ready_in && (nonempty[0] || nonempty[1]);
        if (nonempty[0] && nonempty[1]) begin
            grant_sel = ~last_grant_q;
        end else begin
            grant_sel = !nonempty[0];
        end
        pop[0] = grant_valid && !grant_sel;
        pop[1] = grant_valid && grant_sel;

        for (int i = 0; i < 2; i++) begin
            rd_d[i]  = pop[i]  ? rd_q[i] + PTR_ONE : rd_q[i];
            wr_d[i]  = push[i] ? wr_q[i] + PTR_ONE : wr_q[i];
            cnt_d[i] = cnt_q[i] + (push[i] ? CNT_ONE : '0) - (pop[i] ? CNT_ONE : '0);
        end

        last_grant_d  = grant_valid ? grant_sel : last_grant_q;
        serial_wren_d = grant_valid;
        serial_out_d  = grant_valid ? mem_q[grant_sel][rd_q[grant_sel]] : serial_out_q;

        drop_n       = {1'b0, wren[0] && full[0]} + {1'b0, wren[1] && full[1]};
        drop_sum     = {1'b0, drop_count_q} + {7'b0, drop_n};
        drop_count_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                rd_q[i]  <= '0;
                wr_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
            last_grant_q  <= 1'b1;
            serial_out_q  <= 8'h00;
            serial_wren_q <= 1'b0;
            drop_count_q  <= 8'h00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rd_q[i]  <= rd_d[i];
                wr_q[i]  <= wr_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            last_grant_q  <= last_grant_d;
            serial_out_q  <= serial_out_d;
            serial_wren_q <= serial_wren_d;
            drop_count_q  <= drop_count_d;
        end
    end

    // Storage needs no reset: the counts alone decide which entries are live.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem_q[i][wr_q[i]] <= wr_data[i];
            end
        end
    end

    assign bus.req0_full       = full[0];
    assign bus.req1_full       = full[1];
    assign bus.busy            = nonempty[0] || nonempty[1];
    assign bus.serial_out      = serial_out_q;
    assign bus.serial_wren_out = serial_wren_q;
    assign bus.drop_count      = drop_count_q;
endmodule
